// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state
// encodings and the iteration counter width helper.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sub_nbit.sv
// N-bit ripple-borrow subtractor: diff = a - b, borrow set
// when a < b (unsigned).
module sub_nbit #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i])
                    | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow = bw[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit
// per clock, with start/done handshake and divide-by-zero flag.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);
  import div_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   rem_new;
  logic [WIDTH-1:0] quo_new;
  logic             shift_out_unused;

  // {rem,quo} shifted left; the remainder MSB is always 0 here
  assign shift_out_unused = rem_q[WIDTH];
  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};

  sub_nbit #(.N(WIDTH + 1)) u_sub (
    .a      (rem_sh),
    .b      ({1'b0, b_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign rem_new = borrow ? rem_sh : trial;
  assign quo_new = {quo_sh[WIDTH-1:1], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (B == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    b_d   = b_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (B != '0)) begin
          b_d   = B;
          rem_d = '0;
          quo_d = A;
          cnt_d = CW'(WIDTH);
        end else if (start) begin
          q_d  = '1;
          r_d  = A;
          dz_d = 1'b1;
        end
      end
      ST_RUN: begin
        rem_d = rem_new;
        quo_d = quo_new;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d  = quo_new;
          r_d  = rem_new[WIDTH-1:0];
          dz_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      b_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      b_q   <= b_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

  assign Q  = q_q;
  assign R  = r_q;
  assign DZ = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: driver pushes expected
// results, a done-triggered monitor pops and compares them.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, DZ;
  logic [W-1:0] Q, R;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .DZ    (DZ)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  int   last_acc = 0;
  bit   have_last = 0;
  bit   last_dz = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    ntot++;
    $display("FAIL %s: bound expired", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        ntot++;
        $display("FAIL spurious_done: got done=1 expected none");
      end else begin
        mon_e = sb.pop_front();
        chk("Q", int'(Q), int'(mon_e.q));
        chk("R", int'(R), int'(mon_e.r));
        chk("DZ", int'(DZ), int'(mon_e.dz));
        chk("latency", cyc - mon_e.acc, mon_e.dz ? 0 : W);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz);
    int n;
    exp_t e;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("idle_wait");
    A = a;
    B = b;
    start = 1'b1;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.acc = cyc + 1;
    if (have_last)
      chk("gap", int'((e.acc - last_acc) >= (last_dz ? 2 : W + 2)), 1);
    have_last = 1;
    last_acc = e.acc;
    last_dz = edz;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain");
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_Q"}, int'(Q), 0);
    chk({nm, "_R"}, int'(R), 0);
    chk({nm, "_DZ"}, int'(DZ), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    chk("busy_run", int'(busy), 1);
    drain();

    issue(8'd13, 8'd0, 8'd255, 8'd13, 1'b1);
    @(negedge clk);
    chk("dz_idle", int'(busy), 0);
    drain();

    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    drain();
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    drain();
    issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    drain();
    issue(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    drain();

    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (2) @(negedge clk);
    A = 8'd9;
    B = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_Q", int'(Q), 28);
    chk("hold_R", int'(R), 4);

    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    have_last = 0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd100, 8'd10, 8'd10, 8'd0, 1'b0);
    drain();

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      if (rb == 0) issue(ra, rb, '1, ra, 1'b1);
      else issue(ra, rb, ra / rb, ra % rb, 1'b0);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
